vga_pixel_fetch: RTL and testbench

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

---
 rtl/vga_pixel_fetch.sv | 111 +++++++++++
 tb/tb_vga_pixel_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: scales a Game Boy framebuffer into the VGA raster with a fixed 3-cycle pipeline.
module vga_pixel_fetch #(
  parameter int          X_START    = 80,
  parameter int          Y_START    = 24,
  parameter int          SCALE      = 3,
  parameter int          GB_W       = 160,
  parameter int          GB_H       = 144,
  parameter int          H_VISIBLE  = 640,
  parameter int          V_VISIBLE  = 480,
  parameter logic [11:0] BORDER_RGB = 12'h000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] iRow,
  input  logic [15:0] iCol,
  input  logic        iVgaHsync,
  input  logic        iVgaVsync,
  output logic [14:0] oFbAddr,
  input  logic [1:0]  iFbData,
  input  logic        iPaletteWe,
  input  logic [7:0]  iPalette,
  output logic [3:0]  oRed,
  output logic [3:0]  oGreen,
  output logic [3:0]  oBlue,
  output logic        oHsync,
  output logic        oVsync,
  output logic        oFrameDone
);
  localparam int XW = $clog2(GB_W + 1);
  localparam int YW = $clog2(GB_H + 1);
  localparam int SW = SCALE > 1 ? $clog2(SCALE) : 1;
  localparam logic [15:0] XS = 16'(X_START);
  localparam logic [15:0] XE = 16'(X_START + GB_W * SCALE);
  localparam logic [15:0] YS = 16'(Y_START);
  localparam logic [15:0] YE = 16'(Y_START + GB_H * SCALE);
  localparam logic [15:0] HV = 16'(H_VISIBLE);
  localparam logic [15:0] VV = 16'(V_VISIBLE);
  localparam logic [15:0] GBW = 16'(GB_W);
  localparam logic [XW-1:0] GX_LAST = XW'(GB_W - 1);
  localparam logic [YW-1:0] GY_LAST = YW'(GB_H - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  typedef enum logic [1:0] {PX_BLANK, PX_BORDER, PX_WIN} px_e;
  logic [SW-1:0] subx_q, subx_c, suby_q;
  logic [XW-1:0] gbx_q, gbx_c;
  logic [YW-1:0] gby_q;
  logic [14:0]   row_base, addr_d;
  logic          in_win, col_start, done_d;
  px_e           kind_d, kind1_q, kind2_q;
  logic [7:0]    pal_shadow_q, pal_act_q;
  logic [1:0]    shade;
  logic [3:0]    lvl;
  logic [11:0]   rgb_d, rgb_q;
  logic [2:0]    hs_q, vs_q;
  // Column counters restart combinationally at X_START so that pixel already uses gbx=0.
  always_comb begin
    col_start = iCol == XS;
    in_win = iCol >= XS && iCol < XE && iRow >= YS && iRow < YE;
    subx_c = col_start ? '0 : subx_q;
    gbx_c = col_start ? '0 : gbx_q;
    row_base = '0;
    for (int i = 0; i < 16; i++) row_base = GBW[i] ? row_base + (15'(gby_q) << i) : row_base;
    addr_d = row_base + 15'(gbx_c);
    kind_d = (iCol >= HV || iRow >= VV) ? PX_BLANK : in_win ? PX_WIN : PX_BORDER;
    done_d = in_win && gbx_c == GX_LAST && gby_q == GY_LAST && subx_c == SUB_LAST && suby_q == SUB_LAST;
    shade = 2'(pal_act_q >> {iFbData, 1'b0});
    lvl = shade == 2'd0 ? 4'hF : shade == 2'd1 ? 4'hA : shade == 2'd2 ? 4'h5 : 4'h0;
    rgb_d = kind2_q == PX_WIN ? {3{lvl}} : kind2_q == PX_BORDER ? BORDER_RGB : 12'h000;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      subx_q <= '0;
      suby_q <= '0;
      gbx_q <= '0;
      gby_q <= '0;
      oFbAddr <= '0;
      kind1_q <= PX_BLANK;
      kind2_q <= PX_BLANK;
      rgb_q <= '0;
      hs_q <= '1;
      vs_q <= '1;
      oFrameDone <= 1'b0;
      pal_shadow_q <= 8'hE4;
      pal_act_q <= 8'hE4;
    end else begin
      if (in_win) begin
        subx_q <= subx_c == SUB_LAST ? '0 : subx_c + 1'b1;
        gbx_q <= subx_c == SUB_LAST ? gbx_c + 1'b1 : gbx_c;
        oFbAddr <= addr_d;
      end
      if (iCol == '0 && iRow == YS) begin
        suby_q <= '0;
        gby_q <= '0;
      end else if (iCol == '0 && iRow > YS && iRow < YE) begin
        suby_q <= suby_q == SUB_LAST ? '0 : suby_q + 1'b1;
        gby_q <= suby_q == SUB_LAST ? gby_q + 1'b1 : gby_q;
      end
      kind1_q <= kind_d;
      kind2_q <= kind1_q;
      rgb_q <= rgb_d;
      hs_q <= {hs_q[1:0], iVgaHsync};
      vs_q <= {vs_q[1:0], iVgaVsync};
      oFrameDone <= done_d;
      if (iPaletteWe) pal_shadow_q <= iPalette;
      // Active palette only swaps at frame start; a same-cycle write still sees the old shadow.
      if (iRow == '0 && iCol == '0) pal_act_q <= pal_shadow_q;
    end
  end
  assign {oRed, oGreen, oBlue} = rgb_q;
  assign oHsync = hs_q[2];
  assign oVsync = vs_q[2];
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: drives raster sweeps into a default and a SCALE=2 instance and checks
// every cycle against a division-based reference model plus a table of fixed probe points.
module tb_vga_pixel_fetch;
  logic        Clock = 1'b0, Reset = 1'b0;
  logic [15:0] iRow = '0, iCol = '0;
  logic        iVgaHsync = 1'b1, iVgaVsync = 1'b1;
  logic        iPaletteWe = 1'b0;
  logic [7:0]  iPalette = '0;
  logic [14:0] fb_addr [2];
  logic [1:0]  fb_data [2];
  logic [3:0]  red [2], grn [2], blu [2];
  logic        hs [2], vs [2], done [2];
  logic [1:0]  mem [0:32767];

  vga_pixel_fetch u0 (
    .Clock(Clock), .Reset(Reset), .iRow(iRow), .iCol(iCol), .iVgaHsync(iVgaHsync),
    .iVgaVsync(iVgaVsync), .oFbAddr(fb_addr[0]), .iFbData(fb_data[0]), .iPaletteWe(iPaletteWe),
    .iPalette(iPalette), .oRed(red[0]), .oGreen(grn[0]), .oBlue(blu[0]), .oHsync(hs[0]),
    .oVsync(vs[0]), .oFrameDone(done[0]));

  vga_pixel_fetch #(.X_START(160), .Y_START(96), .SCALE(2)) u1 (
    .Clock(Clock), .Reset(Reset), .iRow(iRow), .iCol(iCol), .iVgaHsync(iVgaHsync),
    .iVgaVsync(iVgaVsync), .oFbAddr(fb_addr[1]), .iFbData(fb_data[1]), .iPaletteWe(iPaletteWe),
    .iPalette(iPalette), .oRed(red[1]), .oGreen(grn[1]), .oBlue(blu[1]), .oHsync(hs[1]),
    .oVsync(vs[1]), .oFrameDone(done[1]));

  always #5 Clock = ~Clock;

  // Synchronous framebuffer: data returns one cycle after the address.
  always @(posedge Clock) begin
    fb_data[0] <= mem[fb_addr[0]];
    fb_data[1] <= mem[fb_addr[1]];
  end

  typedef struct {int r; int c; int i; int a; int rgb;} probe_t;
  probe_t tbl [13];

  int px [2] = '{80, 160};
  int py [2] = '{24, 96};
  int ps [2] = '{3, 2};
  int sp [7] = '{0, 79, 80, 81, 82, 83, 700};
  int n_cmp = 0, n_bad = 0;
  longint cyc = 0;
  int h_r [4], h_c [4];
  logic [7:0] h_act [4];
  logic [7:0] m_shadow = 8'hE4, m_act = 8'hE4;
  int hold [2] = '{0, 0};
  bit hold_ok [2] = '{1, 1};
  int done_cnt [2] = '{0, 0};
  bit chk_en = 0, tbl_en = 0, force_rst = 0;
  int wr_r = -1, wr_c = -1, rst_r = -1, rst_c = -1;
  logic [7:0] wr_v = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at row %0d col %0d", nm, act, exp, iRow, iCol);
    end
  endtask

  function automatic int kind_of(int i, int r, int c);
    if (c >= 640 || r >= 480) return 0;
    if (c >= px[i] && c < px[i] + 160 * ps[i] && r >= py[i] && r < py[i] + 144 * ps[i]) return 2;
    return 1;
  endfunction

  function automatic int addr_of(int i, int r, int c);
    return ((r - py[i]) / ps[i]) * 160 + (c - px[i]) / ps[i];
  endfunction

  function automatic logic [11:0] colour(int shade, logic [7:0] pal);
    int idx = int'((pal >> (2 * shade)) & 8'd3);
    logic [3:0] v = 4'(15 - 5 * idx);
    return {v, v, v};
  endfunction

  task automatic fill(input int mode);
    for (int a = 0; a < 32768; a++) mem[a] = mode == 0 ? 2'(a) : mode == 1 ? 2'd0 : 2'($urandom);
  endtask

  task automatic tick(input int r, input int c);
    int p, q, k, kq;
    logic [11:0] want;
    iRow = 16'(r);
    iCol = 16'(c);
    iVgaHsync = !(c >= 656 && c < 752);
    iVgaVsync = !(r == 490 || r == 491);
    iPaletteWe = (r == wr_r && c == wr_c);
    iPalette = wr_v;
    Reset = force_rst || (r == rst_r && c == rst_c);
    p = int'(cyc % 4);
    q = int'((cyc + 2) % 4);
    h_r[p] = r;
    h_c[p] = c;
    h_act[p] = m_act;
    if (Reset) begin
      m_act = 8'hE4;
      m_shadow = 8'hE4;
    end else begin
      if (r == 0 && c == 0) m_act = m_shadow;
      if (iPaletteWe) m_shadow = wr_v;
    end
    @(posedge Clock);
    #1;
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        chk("rst_addr", 32'(fb_addr[i]), 0);
        chk("rst_rgb", 32'({red[i], grn[i], blu[i]}), 0);
        chk("rst_hsync", 32'(hs[i]), 1);
        chk("rst_vsync", 32'(vs[i]), 1);
        chk("rst_done", 32'(done[i]), 0);
        hold[i] = 0;
        hold_ok[i] = 0;
      end
      chk_en = 0;
    end else if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        k = kind_of(i, r, c);
        if (k == 2) begin
          hold[i] = addr_of(i, r, c);
          hold_ok[i] = 1;
        end
        if (hold_ok[i]) chk("addr", 32'(fb_addr[i]), 32'(hold[i]));
        chk("frame_done", 32'(done[i]),
            32'(r == py[i] + 144 * ps[i] - 1 && c == px[i] + 160 * ps[i] - 1));
        if (done[i]) done_cnt[i]++;
        if (cyc >= 2) begin
          kq = kind_of(i, h_r[q], h_c[q]);
          want = kq == 2 ? colour(int'(mem[addr_of(i, h_r[q], h_c[q])]), h_act[p]) : 12'h000;
          chk("rgb", 32'({red[i], grn[i], blu[i]}), 32'(want));
          chk("hsync", 32'(hs[i]), 32'(!(h_c[q] >= 656 && h_c[q] < 752)));
          chk("vsync", 32'(vs[i]), 32'(!(h_r[q] == 490 || h_r[q] == 491)));
        end
      end
      if (tbl_en) for (int e = 0; e < 13; e++) begin
        if (tbl[e].r == r && tbl[e].c == c && tbl[e].a >= 0)
          chk("probe_addr", 32'(fb_addr[tbl[e].i]), 32'(tbl[e].a));
        if (cyc >= 2 && tbl[e].r == h_r[q] && tbl[e].c == h_c[q] && tbl[e].rgb >= 0)
          chk("probe_rgb", 32'({red[tbl[e].i], grn[tbl[e].i], blu[tbl[e].i]}), 32'(tbl[e].rgb));
      end
    end
    cyc++;
  endtask

  // Dense rows carry every column; the rest only col 0 plus a short contiguous run from X_START.
  task automatic run_frame();
    int dr = $urandom_range(28, 454);
    done_cnt = '{0, 0};
    for (int r = 0; r < 525; r++)
      if (r inside {23, 24, 27, 96, 200, 383, 455} || r == dr)
        for (int c = 0; c < 800; c++) tick(r, c);
      else
        foreach (sp[j]) tick(r, sp[j]);
    if (chk_en) for (int i = 0; i < 2; i++) chk("frame_done_count", 32'(done_cnt[i]), 1);
  endtask

  initial begin
    tbl[0]  = '{24, 80, 0, 0, 'hFFF};
    tbl[1]  = '{24, 82, 0, 0, 'hFFF};
    tbl[2]  = '{24, 83, 0, 1, 'hAAA};
    tbl[3]  = '{27, 80, 0, 160, 'hFFF};
    tbl[4]  = '{455, 557, 0, 23039, 'h000};
    tbl[5]  = '{455, 559, 0, 23039, 'h000};
    tbl[6]  = '{24, 79, 0, -1, 'h000};
    tbl[7]  = '{24, 560, 0, -1, 'h000};
    tbl[8]  = '{23, 80, 0, -1, 'h000};
    tbl[9]  = '{0, 700, 0, -1, 'h000};
    tbl[10] = '{96, 162, 1, 1, 'hAAA};
    tbl[11] = '{383, 478, 1, 23039, 'h000};
    tbl[12] = '{383, 479, 1, 23039, 'h000};
    fill(0);
    force_rst = 1;
    tick(524, 798);
    tick(524, 799);
    force_rst = 0;
    hold = '{0, 0};
    hold_ok = '{1, 1};
    chk_en = 1;
    tbl_en = 1;
    run_frame();
    tbl_en = 0;
    fill(1);
    wr_r = $urandom_range(30, 450);
    wr_c = 0;
    wr_v = 8'h1B;
    run_frame();
    wr_r = 0;
    wr_v = 8'($urandom);
    run_frame();
    wr_r = -1;
    fill(2);
    rst_r = 200;
    rst_c = 300;
    run_frame();
    rst_r = -1;
    fill(0);
    chk_en = 1;
    tbl_en = 1;
    run_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
